ysyx_22041211_mdu_seq: RTL and testbench
========================================

Name: ysyx_22041211_mdu_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer for the EXU. It accepts one operation through a valid/ready handshake and iterates over 32 steps. Each step's add/subtract runs on an internal instance of the team's 32-bit ALU. The 32-bit result is returned through a second valid/ready handshake. It sits beside the single-cycle ALU path, and the EXU stalls on it for M-extension instructions.

Parameters:
DATA_LEN, 32, operand/result width; only 32 supported
ITER_N, 32, iteration count; must equal DATA_LEN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  sequencer can accept (IDLE only)
mdu_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  in  DATA_LEN  rs1 value (multiplicand / dividend)
src2  in  DATA_LEN  rs2 value (multiplier / divisor)
flush  in  1  abort in-flight operation (branch/exception kill)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  DATA_LEN  final result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal registers 0.
- Accept: a transfer occurs when in_valid & in_ready on a clk edge. op, src1 and src2 are latched and the block goes to PREP.
- PREP (1 cycle):
  - Record operand signs: DIV/REM/MULH use both signs; MULHSU uses src1's sign only.
  - Replace signed-negative operands with their two's-complement magnitude.
  - Record the result-negate flag: sign1^sign2 for quotient and MUL*, sign1 for remainder.
- PREP special cases, which skip ITER and go to DONE:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = src1.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Otherwise PREP goes to ITER with cnt=0.
- ITER, multiply (shift-add, {hi,lo} 64-bit, multiplier in lo):
  - If lo[0]=1, hi_sum = ALU(add, hi, mcand) with carry = (hi_sum < hi) unsigned; otherwise hi_sum = hi and carry = 0.
  - Then {hi,lo} <= {carry, hi_sum, lo[31:1]}.
- ITER, divide (restoring, rem r, quotient shifts into dividend register q):
  - shifted = {r, q[31]} (33 bits); diff = ALU(sub, shifted[31:0], divisor).
  - If shifted[32] | (shifted[31:0] >= divisor): r <= diff, q <= {q[30:0],1}. Otherwise r <= shifted[31:0], q <= {q[30:0],0}.
- ITER ALU usage: the ALU control is 4'b0000 (add) for multiply and 4'b0001 (sub) for divide. Any other code in ITER is a bug.
- ITER exit: cnt increments each cycle; when cnt==ITER_N-1 the next state is FIX.
- FIX (1 cycle):
  - If the negate flag is set, negate the 64-bit product (lo = ~lo+1, hi = ~hi + (lo==0)) or the selected 32-bit quotient/remainder.
  - Select the result: MUL=lo, MULH*/MULHU=hi, DIV*=q, REM*=r. Register it into result.
  - Go to DONE.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid & out_ready, go to IDLE; in_ready becomes 1 the next cycle. There is no same-cycle re-accept.
- Latency from accept edge to out_valid high:
  - 35 cycles normal (PREP 1 + ITER 32 + FIX 1 + register to DONE).
  - 2 cycles for special cases.
- flush:
  - In any state other than IDLE: next state IDLE, out_valid=0, result unchanged, nothing emitted.
  - flush has priority over out_ready in DONE.
  - flush in IDLE with in_valid high: the request is not accepted.
- Signedness rules: MULHU and DIVU/REMU never negate. Signed magnitudes of 0x80000000 stay 0x80000000 and are treated as unsigned 2^31.
- Reset mid-operation: asynchronous return to reset values; the operation is lost.
- Inputs src1, src2 and mdu_op are ignored outside the accept cycle.

Decomposition:
- Shared package ysyx_22041211_mdu_pkg:
  - mdu_op encodings (funct3 values above).
  - State encoding IDLE/PREP/ITER/FIX/DONE (3-bit).
  - ALU control constants ALU_ADD=4'b0000 and ALU_SUB=4'b0001, shared with the decoder.
- Sub-module: one instance of ysyx_22041211_ALU for the per-iteration add/sub. The FSM, counter, operand registers and sign fix-up stay in this module.

Test Plan:
- MUL 7 × 6 (0x7, 0x6), out_ready=1 → out_valid exactly 35 cycles after accept, result=0x0000002A; busy low the cycle after.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIV and REM by zero with src1=0x12345678 → 0xFFFFFFFF / 0x12345678, out_valid 2 cycles after accept. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0 throughout. Raise out_ready → next cycle IDLE, in_ready=1.
- flush asserted at ITER cnt=15 → IDLE next cycle, no out_valid pulse. A following DIVU 100/7 → 14. Also assert rst_n=0 asynchronously mid-ITER → outputs immediately take their reset values.

Source files
------------

// File: rtl/ysyx_22041211_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM state encoding and the ALU control codes it shares with the decoder.
package ysyx_22041211_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/ysyx_22041211_ALU.sv
// Team 32-bit combinational ALU; the MDU only drives the add and sub codes.
module ysyx_22041211_ALU #(
  parameter int DATA_LEN = 32
) (
  input  logic [3:0]          alu_ctrl,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] y
);
  localparam int SH_W = $clog2(DATA_LEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // NOTE: every path assigns y (default first), so no latch is inferred.
  always_comb begin
    y = '0;
    case (alu_ctrl)
      4'b0000: y = a + b;
      4'b0001: y = a - b;
      4'b0010: y = a << shamt;
      4'b0011: y = {{(DATA_LEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0100: y = {{(DATA_LEN-1){1'b0}}, a < b};
      4'b0101: y = a ^ b;
      4'b0110: y = a >> shamt;
      4'b0111: y = $signed(a) >>> shamt;
      4'b1000: y = a | b;
      4'b1001: y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_mdu_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply / restoring divide, one bit
// per cycle over 32 iterations, with sign fix-up before and after.
module ysyx_22041211_mdu_seq
  import ysyx_22041211_mdu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ITER_N   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          mdu_op,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] result,
  output logic                busy
);
  localparam int CNT_W = $clog2(ITER_N);

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q;
  logic [DATA_LEN-1:0] src1_q, src2_q;
  logic [DATA_LEN-1:0] hi_q, lo_q, opb_q;   // hi/lo double as remainder/quotient
  logic                neg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_LEN-1:0] result_q;

  logic accept, is_div, is_rem;
  assign accept = in_valid & in_ready;
  assign is_div = op_is_div(op_q);
  assign is_rem = is_div & op_q[1];

  // Operand sign handling in PREP
  logic                sign1, sign2, div_zero, div_ovf, special;
  logic [DATA_LEN-1:0] mag1, mag2, special_res;
  assign sign1 = src1_q[DATA_LEN-1] & (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sign2 = src2_q[DATA_LEN-1] & (op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign mag1  = sign1 ? (~src1_q + 1'b1) : src1_q;
  assign mag2  = sign2 ? (~src2_q + 1'b1) : src2_q;
  assign div_zero = is_div & (src2_q == '0);
  assign div_ovf  = (op_q inside {OP_DIV, OP_REM}) &
                    (src1_q == {1'b1, {(DATA_LEN-1){1'b0}}}) & (src2_q == '1);
  assign special  = div_zero | div_ovf;
  assign special_res = div_zero ? (is_rem ? src1_q : '1)
                                : (is_rem ? '0 : {1'b1, {(DATA_LEN-1){1'b0}}});

  // Per-iteration add/sub on the shared ALU
  logic [DATA_LEN:0]   shifted;
  logic [DATA_LEN-1:0] alu_a, alu_y, hi_sum;
  logic [3:0]          alu_ctrl;
  logic                carry, take;
  assign shifted  = {hi_q, lo_q[DATA_LEN-1]};
  assign alu_a    = is_div ? shifted[DATA_LEN-1:0] : hi_q;
  assign alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
  assign hi_sum   = lo_q[0] ? alu_y : hi_q;
  assign carry    = lo_q[0] & (alu_y < hi_q);
  assign take     = shifted[DATA_LEN] | (shifted[DATA_LEN-1:0] >= opb_q);

  ysyx_22041211_ALU #(.DATA_LEN(DATA_LEN)) u_alu (
    .alu_ctrl (alu_ctrl),
    .a        (alu_a),
    .b        (opb_q),
    .y        (alu_y)
  );

  // Final sign correction and result selection in FIX
  logic [DATA_LEN-1:0] lo_neg, hi_neg, fix_res;
  assign lo_neg = ~lo_q + 1'b1;
  assign hi_neg = ~hi_q + {{(DATA_LEN-1){1'b0}}, (lo_q == '0)};

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = neg_q ? lo_neg : lo_q;
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = neg_q ? hi_neg : hi_q;
      OP_DIV, OP_DIVU:              fix_res = neg_q ? lo_neg : lo_q;
      default:                      fix_res = neg_q ? (~hi_q + 1'b1) : hi_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_PREP;
      S_PREP:  state_d = special ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == CNT_W'(ITER_N - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A kill wins over everything, including a DONE handshake
    if (flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      src1_q   <= '0;
      src2_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= mdu_op_e'(mdu_op);
          src1_q <= src1;
          src2_q <= src2;
        end
        S_PREP: begin
          cnt_q <= '0;
          neg_q <= is_rem ? sign1 : (sign1 ^ sign2);
          hi_q  <= '0;
          lo_q  <= is_div ? mag1 : mag2;
          opb_q <= is_div ? mag2 : mag1;
          if (special) result_q <= special_res;
        end
        S_ITER: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div) begin
            hi_q <= take ? alu_y : shifted[DATA_LEN-1:0];
            lo_q <= {lo_q[DATA_LEN-2:0], take};
          end else begin
            hi_q <= {carry, hi_sum[DATA_LEN-1:1]};
            lo_q <= {hi_sum[0], lo_q[DATA_LEN-1:1]};
          end
        end
        S_FIX:   result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~flush;
  assign out_valid = (state_q == S_DONE) & ~flush;
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22041211_mdu_seq.sv
// Directed bench for the RV32M sequencer: arithmetic results, latency,
// backpressure, flush and asynchronous reset.
module tb_ysyx_22041211_mdu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  mdu_op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_22041211_mdu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mdu_op    (mdu_op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge; it is accepted at the following posedge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; mdu_op = op; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mdu_op = 3'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  // Cycle 1 is the cycle following the accept edge; returns the cycle in
  // which out_valid is first seen high (sampled at negedge).
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    out_ready = 1'b1;
    launch(op, a, b, tag);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    check({tag, " in_ready after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; mdu_op = 3'd0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    #3;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b000, 32'h7, 32'h6, 32'h0000_002A, 35, "MUL 7x6");
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, "MULH -1x-1");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "MULHU");
    do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 35, "MULHSU -1x2");
    do_op(3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 35, "DIV -7/2");
    do_op(3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 35, "REM -7%2");
    do_op(3'b101, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 35, "DIVU");
    do_op(3'b100, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 2, "DIV by 0");
    do_op(3'b110, 32'h1234_5678, 32'h0, 32'h1234_5678, 2, "REM by 0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "DIV ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, "REM ovf");
    do_op(3'b000, 32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 35, "MUL min x3");

    // Backpressure: hold the result in DONE for 10 cycles
    out_ready = 1'b0;
    launch(3'b000, 32'h0001_2345, 32'h10, "BP");
    wait_valid(lat);
    check("BP latency", 32'(lat), 32'd35);
    for (int i = 0; i < 10; i++) begin
      check("BP result held", result, 32'h0012_3450);
      check("BP out_valid held", {31'd0, out_valid}, 32'd1);
      check("BP in_ready low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("BP busy after", {31'd0, busy}, 32'd0);
    check("BP in_ready after", {31'd0, in_ready}, 32'd1);

    // Flush at ITER cnt=15, i.e. cycle 17 after accept
    launch(3'b000, 32'h1111_1111, 32'h2222_2222, "FLUSH");
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("FLUSH busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("FLUSH busy after", {31'd0, busy}, 32'd0);
    check("FLUSH in_ready after", {31'd0, in_ready}, 32'd1);
    check("FLUSH result kept", result, 32'h0012_3450);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    check("FLUSH no out_valid", {31'd0, seen_valid}, 32'd0);

    // flush in IDLE blocks a request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; mdu_op = 3'b000; src1 = 32'h5; src2 = 32'h5;
    #1 check("IDLE flush in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("IDLE flush not accepted", {31'd0, busy}, 32'd0);

    do_op(3'b101, 32'd100, 32'd7, 32'd14, 35, "DIVU 100/7");

    // Asynchronous reset in the middle of ITER
    launch(3'b100, 32'd1000, 32'd3, "RST");
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("RST out_valid", {31'd0, out_valid}, 32'd0);
    check("RST in_ready", {31'd0, in_ready}, 32'd1);
    check("RST busy", {31'd0, busy}, 32'd0);
    check("RST result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b111, 32'd100, 32'd7, 32'd2, 35, "REMU 100%7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
